// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader: drains a byte FIFO and serializes each byte as start + DBIT data (LSB first) + stop.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_tick            16x-oversampling baud tick, one clk wide
//   fifo_empty        FIFO empty flag
//   fifo_data         FIFO read data, valid the clk after fifo_rd
//   fifo_rd           one-clk FIFO read strobe, high only in FETCH
//   tx                registered serial output, idle high
//   tx_done_tick      one-clk pulse in the first IDLE cycle after a frame
//   busy              high whenever not IDLE
module uart_tx_fifo_reader #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_tick,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_done_tick,
    output logic            busy
);
    localparam int TW = $clog2(SB_TICK > 16 ? SB_TICK : 16);
    localparam int BW = DBIT > 1 ? $clog2(DBIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(15);
    localparam logic [TW-1:0] S_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:  state_d = fifo_empty ? IDLE : FETCH;
            FETCH: state_d = LOAD;
            LOAD: begin
                shreg_d = fifo_data;
                tick_d  = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: if (s_tick) begin
                tick_d  = (tick_q == T_LAST) ? '0 : tick_q + 1'b1;
                state_d = (tick_q == T_LAST) ? DATA : START;
            end
            DATA: if (s_tick) begin
                if (tick_q == T_LAST) begin
                    tick_d  = '0;
                    shreg_d = shreg_q >> 1;
                    state_d = (bit_q == B_LAST) ? STOP : DATA;
                    bit_d   = (bit_q == B_LAST) ? bit_q : bit_q + 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            STOP: if (s_tick) begin
                tick_d  = (tick_q == S_LAST) ? '0 : tick_q + 1'b1;
                state_d = (tick_q == S_LAST) ? IDLE : STOP;
                done_d  = (tick_q == S_LAST);
            end
            default: state_d = IDLE;
        endcase
        // tx follows the next state so it switches on the same edge as the state.
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shreg_d[0] : 1'b1;
    end

    assign fifo_rd      = (state_q == FETCH);
    assign busy         = (state_q != IDLE);
    assign tx           = tx_q;
    assign tx_done_tick = done_q;
endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// tb_uart_tx_fifo_reader: directed bench for uart_tx_fifo_reader (1 and 2 stop-bit instances).
module tb_uart_tx_fifo_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_tick = 1'b0;
    logic fe1 = 1'b1, fe2 = 1'b1;
    logic [7:0] fd1 = 8'h00, fd2 = 8'h00;
    logic rd1, tx1, dn1, bz1, rd2, tx2, dn2, bz2;
    int errors = 0, checks = 0, tick_n = 0, rd_cnt1 = 0, rd_cnt2 = 0;
    bit scramble = 1'b0;
    logic [7:0] q1[$], q2[$];

    uart_tx_fifo_reader #(.DBIT(8), .SB_TICK(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .fifo_empty(fe1), .fifo_data(fd1),
        .fifo_rd(rd1), .tx(tx1), .tx_done_tick(dn1), .busy(bz1)
    );
    uart_tx_fifo_reader #(.DBIT(8), .SB_TICK(32)) dut2 (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .fifo_empty(fe2), .fifo_data(fd2),
        .fifo_rd(rd2), .tx(tx2), .tx_done_tick(dn2), .busy(bz2)
    );

    always #5 clk = ~clk;

    // Baud tick: one clk high every tick_n clocks, changed on the falling edge.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (tick_n == 0) s_tick = 1'b0;
            else begin
                s_tick = (cnt == 0);
                cnt = (cnt + 1) % tick_n;
            end
        end
    end

    // FIFO model: read data registered from the rd cycle, so it is valid in LOAD.
    initial begin
        forever begin
            @(negedge clk);
            if (rd1) begin
                rd_cnt1++;
                if (q1.size() > 0) fd1 = q1.pop_front();
            end else if (scramble && !tx1) fd1 = 8'($urandom);
            if (rd2) begin
                rd_cnt2++;
                if (q2.size() > 0) fd2 = q2.pop_front();
            end
            fe1 = (q1.size() == 0);
            fe2 = (q2.size() == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int c);
        int i;
        i = c / 16;
        return (i == 0) ? 1'b0 : (i <= 8) ? b[i-1] : 1'b1;
    endfunction

    // Follows one frame by counting s_ticks from the START edge and checks tx at
    // each bit's first and last tick, then the done pulse and the following cycle.
    task automatic recv(input bit sel, input logic [7:0] b, input int sb, input bit next_rd, input string tag);
        int c, w, total;
        bit t;
        total = 16 * 9 + sb;
        w = 0;
        while ((sel ? tx2 : tx1) !== 1'b0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " start seen"}, 32'(w < 3000), 32'd1);
        if (w >= 3000) return;
        chk({tag, " busy"}, 32'(sel ? bz2 : bz1), 32'd1);
        c = 0;
        while (c < total) begin
            @(posedge clk);
            t = s_tick;
            @(negedge clk);
            if (t) begin
                c++;
                if (c < total && (c % 16 == 0 || c % 16 == 15))
                    chk($sformatf("%s tx@tick%0d", tag, c), 32'(sel ? tx2 : tx1), 32'(exp_bit(b, c)));
                if (c == total - 1)
                    chk({tag, " no early done"}, 32'(sel ? dn2 : dn1), 32'd0);
            end
        end
        chk({tag, " done"}, 32'(sel ? dn2 : dn1), 32'd1);
        chk({tag, " idle tx"}, 32'(sel ? tx2 : tx1), 32'd1);
        chk({tag, " idle busy"}, 32'(sel ? bz2 : bz1), 32'd0);
        @(negedge clk);
        chk({tag, " done one clk"}, 32'(sel ? dn2 : dn1), 32'd0);
        chk({tag, " next rd"}, 32'(sel ? rd2 : rd1), 32'(next_rd));
    endtask

    initial begin
        int w, c, bad;
        bit t;
        repeat (3) @(negedge clk);
        chk("reset tx1", 32'(tx1), 32'd1);
        chk("reset busy1", 32'(bz1), 32'd0);
        chk("reset rd1", 32'(rd1), 32'd0);
        chk("reset done1", 32'(dn1), 32'd0);
        chk("reset tx2", 32'(tx2), 32'd1);
        chk("reset busy2", 32'(bz2), 32'd0);
        rst_n = 1'b1;
        tick_n = 4;
        repeat (5) @(negedge clk);

        q1.push_back(8'hA5);
        recv(1'b0, 8'hA5, 16, 1'b0, "single");
        chk("single rd count", 32'(rd_cnt1), 32'd1);

        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (rd1 || !tx1 || bz1 || dn1) bad++;
        end
        chk("idle bad cycles", 32'(bad), 32'd0);

        q1.push_back(8'h3C);
        q1.push_back(8'h00);
        recv(1'b0, 8'h3C, 16, 1'b1, "b2b first");
        recv(1'b0, 8'h00, 16, 1'b0, "b2b second");
        chk("b2b rd count", 32'(rd_cnt1), 32'd3);

        q1.push_back(8'hFF);
        w = 0;
        while (tx1 !== 1'b0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("rst start seen", 32'(w < 3000), 32'd1);
        c = 0;
        while (c < 72 && w < 3000) begin
            @(posedge clk);
            t = s_tick;
            @(negedge clk);
            if (t) c++;
        end
        chk("rst bit3 level", 32'(tx1), 32'd1);
        chk("rst bit3 busy", 32'(bz1), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst async tx", 32'(tx1), 32'd1);
        chk("rst async busy", 32'(bz1), 32'd0);
        chk("rst async rd", 32'(rd1), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (rd1 || !tx1 || bz1 || dn1) bad++;
        end
        chk("post rst idle", 32'(bad), 32'd0);
        chk("post rst rd count", 32'(rd_cnt1), 32'd4);

        tick_n = 1;
        q2.push_back(8'h55);
        recv(1'b1, 8'h55, 32, 1'b0, "two stop");
        chk("two stop rd count", 32'(rd_cnt2), 32'd1);

        scramble = 1'b1;
        q1.push_back(8'h96);
        recv(1'b0, 8'h96, 16, 1'b0, "align");
        scramble = 1'b0;
        chk("align rd count", 32'(rd_cnt1), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
